// File: rtl/com_stream_bridge_if.sv
// Bundle of the CPU-side capture inputs and the receiver-side serial outputs of com_stream_bridge.
// The master drives MemtoReg/COM/ReadData; the slave (the bridge) drives the chunk stream and status.
interface com_stream_bridge_if #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 8,
    parameter int DEPTH  = 8
);
    logic                     MemtoReg;
    logic                     COM;
    logic [DATA_W-1:0]        ReadData;
    logic                     clk_out;
    logic [OUT_W-1:0]         ReadDataOut;
    logic [$clog2(DEPTH):0]   level;
    logic                     busy;
    logic                     overflow;

    modport master (
        output MemtoReg, COM, ReadData,
        input  clk_out, ReadDataOut, level, busy, overflow
    );

    modport slave (
        input  MemtoReg, COM, ReadData,
        output clk_out, ReadDataOut, level, busy, overflow
    );
endinterface

// File: rtl/com_stream_bridge.sv
// Captures CPU load words flagged by COM into a FIFO and serialises each word as OUT_W-bit
// chunks, every chunk held for one full clk_out period (DIV cycles low, then DIV cycles high).
module com_stream_bridge #(
    parameter int DATA_W    = 32,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 8,
    parameter int DIV       = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    com_stream_bridge_if.slave bus
);
    localparam int NCH   = DATA_W / OUT_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                clk_out_q, clk_out_d;
    logic [DATA_W-1:0]   sreg_q, sreg_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                overflow_q, overflow_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                pop, push_req, push_ok;

    // The chunk on the wire always sits at the end of the shift register that leaves first.
    function automatic logic [OUT_W-1:0] out_chunk(input logic [DATA_W-1:0] s);
        return MSB_FIRST ? s[DATA_W-1 -: OUT_W] : s[OUT_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] next_chunk(input logic [DATA_W-1:0] s);
        return MSB_FIRST ? (s << OUT_W) : (s >> OUT_W);
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        clk_out_d = clk_out_q;
        sreg_d    = sreg_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop       = 1'b1;
                    sreg_d    = mem_q[rd_ptr_q];
                    idx_d     = '0;
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                    state_d   = LOW;
                end
            end
            LOW: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d     = '0;
                    clk_out_d = 1'b1;
                    state_d   = HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                    state_d   = LOW;
                    if (idx_q != IDX_LAST) begin
                        idx_d  = idx_q + IDX_W'(1);
                        sreg_d = next_chunk(sreg_q);
                    end else if (level_q != '0) begin
                        // Chain straight into the next queued word without an idle cycle.
                        pop    = 1'b1;
                        sreg_d = mem_q[rd_ptr_q];
                        idx_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the same edge pops a word.
    always_comb begin
        push_req   = bus.COM & bus.MemtoReg;
        push_ok    = push_req && ((level_q != LVL_FULL) || pop);
        overflow_d = overflow_q | (push_req & ~push_ok);
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q + LW'(push_ok) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            clk_out_q  <= 1'b0;
            sreg_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            clk_out_q  <= clk_out_d;
            sreg_q     <= sreg_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem_q[wr_ptr_q] <= bus.ReadData;
        end
    end

    assign bus.clk_out     = clk_out_q;
    assign bus.ReadDataOut = out_chunk(sreg_q);
    assign bus.level       = level_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = (state_q != IDLE) || (level_q != '0);
endmodule

// File: tb/tb_com_stream_bridge.sv
// Bench for com_stream_bridge: a default-parameter instance and an MSB_FIRST/DIV=1/DEPTH=4 instance
// share the same stimulus and are both compared every cycle against a word-level reference model.
module tb_com_stream_bridge;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    com_stream_bridge_if #(.DATA_W(32), .OUT_W(8), .DEPTH(8)) bus0 ();
    com_stream_bridge_if #(.DATA_W(32), .OUT_W(8), .DEPTH(4)) bus1 ();

    com_stream_bridge #(.DATA_W(32), .OUT_W(8), .DEPTH(8), .DIV(2), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    com_stream_bridge #(.DATA_W(32), .OUT_W(8), .DEPTH(4), .DIV(1), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a circular word store plus "position within the current word" arithmetic.
    localparam int NCH = 4;
    logic [31:0] m_mem [2][8];
    int          m_head [2];
    int          m_cnt [2];
    int          m_pos [2];
    bit          m_act [2];
    bit          m_ovf [2];
    logic [31:0] m_word [2];
    logic [7:0]  m_dout [2];

    function automatic int mdiv(int i);   return (i == 0) ? 2 : 1; endfunction
    function automatic int mdepth(int i); return (i == 0) ? 8 : 4; endfunction
    function automatic bit mmsb(int i);   return (i == 0) ? 1'b0 : 1'b1; endfunction

    function automatic logic [7:0] mchunk(logic [31:0] w, int k, bit msb);
        int s;
        s = msb ? (NCH - 1 - k) : k;
        return w[s*8 +: 8];
    endfunction

    task automatic model_pop(int i);
        m_word[i] = m_mem[i][m_head[i]];
        m_head[i] = (m_head[i] + 1) % mdepth(i);
        m_cnt[i]  = m_cnt[i] - 1;
        m_pos[i]  = 0;
    endtask

    task automatic model_edge(int i, bit r, bit req, logic [31:0] d);
        int wc;
        wc = NCH * 2 * mdiv(i);
        if (r) begin
            m_head[i] = 0; m_cnt[i] = 0; m_pos[i] = 0;
            m_act[i] = 1'b0; m_ovf[i] = 1'b0; m_dout[i] = '0;
        end else begin
            if (m_act[i]) begin
                m_pos[i] = m_pos[i] + 1;
                if (m_pos[i] == wc) begin
                    if (m_cnt[i] > 0) model_pop(i);
                    else m_act[i] = 1'b0;
                end
            end else if (m_cnt[i] > 0) begin
                model_pop(i);
                m_act[i] = 1'b1;
            end
            if (req) begin
                if (m_cnt[i] < mdepth(i)) begin
                    m_mem[i][(m_head[i] + m_cnt[i]) % mdepth(i)] = d;
                    m_cnt[i] = m_cnt[i] + 1;
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end
            if (m_act[i]) m_dout[i] = mchunk(m_word[i], m_pos[i] / (2 * mdiv(i)), mmsb(i));
        end
    endtask

    task automatic chk(string name, int act, int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(bit r, bit c, bit m, logic [31:0] d);
        int a_clk [2], a_dout [2], a_lvl [2], a_busy [2], a_ovf [2];
        int e_clk;
        reset = r;
        bus0.COM = c; bus0.MemtoReg = m; bus0.ReadData = d;
        bus1.COM = c; bus1.MemtoReg = m; bus1.ReadData = d;
        @(posedge clk);
        model_edge(0, r, c & m, d);
        model_edge(1, r, c & m, d);
        #1;
        a_clk[0] = int'(bus0.clk_out); a_dout[0] = int'(bus0.ReadDataOut); a_lvl[0] = int'(bus0.level);
        a_busy[0] = int'(bus0.busy); a_ovf[0] = int'(bus0.overflow);
        a_clk[1] = int'(bus1.clk_out); a_dout[1] = int'(bus1.ReadDataOut); a_lvl[1] = int'(bus1.level);
        a_busy[1] = int'(bus1.busy); a_ovf[1] = int'(bus1.overflow);
        for (int i = 0; i < 2; i++) begin
            e_clk = (m_act[i] && ((m_pos[i] % (2 * mdiv(i))) >= mdiv(i))) ? 1 : 0;
            chk($sformatf("model_clk_out[%0d]", i), a_clk[i], e_clk);
            chk($sformatf("model_dout[%0d]", i), a_dout[i], int'(m_dout[i]));
            chk($sformatf("model_level[%0d]", i), a_lvl[i], m_cnt[i]);
            chk($sformatf("model_busy[%0d]", i), a_busy[i], (m_act[i] || m_cnt[i] > 0) ? 1 : 0);
            chk($sformatf("model_overflow[%0d]", i), a_ovf[i], int'(m_ovf[i]));
        end
    endtask

    typedef struct {
        bit          r, c, m;
        logic [31:0] d;
        bit          eclk;
        logic [7:0]  edout0;
        logic [7:0]  edout1;
        int          elvl;
        bit          ebusy;
        bit          eovf;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(bit r, bit c, bit m, logic [31:0] d, bit eclk,
                                logic [7:0] e0, logic [7:0] e1, int lvl, bit bsy, bit ovf);
        vec_t v;
        v.r = r; v.c = c; v.m = m; v.d = d; v.eclk = eclk;
        v.edout0 = e0; v.edout1 = e1; v.elvl = lvl; v.ebusy = bsy; v.eovf = ovf;
        return v;
    endfunction

    logic [31:0] w [10];
    logic [7:0]  cap [$];
    logic [31:0] wa;
    bit          prev_clk;
    int          n;
    bit          fell;
    int          p;

    initial begin
        total = 0; bad = 0;
        reset = 1'b1;
        bus0.COM = 1'b0; bus0.MemtoReg = 1'b0; bus0.ReadData = '0;
        bus1.COM = 1'b0; bus1.MemtoReg = 1'b0; bus1.ReadData = '0;

        // Reset values, one word serialised in both chunk orders, then non-qualifying requests.
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h12345678, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'hAABBCCDD, 0, 8'h00, 8'h00, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 8'hDD, 8'hAA, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 8'hDD, 8'hAA, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 8'hDD, 8'hBB, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 8'hDD, 8'hBB, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 8'hCC, 8'hCC, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 8'hCC, 8'hCC, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 8'hCC, 8'hDD, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 8'hCC, 8'hDD, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 8'hBB, 8'hDD, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 8'hBB, 8'hDD, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 8'hBB, 8'hDD, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 8'hBB, 8'hDD, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 8'hAA, 8'hDD, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 8'hAA, 8'hDD, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 8'hAA, 8'hDD, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 8'hAA, 8'hDD, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 8'hAA, 8'hDD, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 0, 8'hAA, 8'hDD, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 0, 8'hAA, 8'hDD, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 0, 8'hAA, 8'hDD, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'hFFFFFFFF, 0, 8'hAA, 8'hDD, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'hFFFFFFFF, 0, 8'hAA, 8'hDD, 0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].r, tbl[k].c, tbl[k].m, tbl[k].d);
            chk($sformatf("tbl%0d_clk_out", k), int'(bus0.clk_out), int'(tbl[k].eclk));
            chk($sformatf("tbl%0d_dout", k), int'(bus0.ReadDataOut), int'(tbl[k].edout0));
            chk($sformatf("tbl%0d_dout_msb", k), int'(bus1.ReadDataOut), int'(tbl[k].edout1));
            chk($sformatf("tbl%0d_level", k), int'(bus0.level), tbl[k].elvl);
            chk($sformatf("tbl%0d_busy", k), int'(bus0.busy), int'(tbl[k].ebusy));
            chk($sformatf("tbl%0d_overflow", k), int'(bus0.overflow), int'(tbl[k].eovf));
        end

        // Ten back-to-back pushes: the tenth is dropped, the other nine stream with no gap.
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        cap.delete();
        prev_clk = 1'b0;
        for (int k = 0; k < 10; k++) begin
            w[k] = $urandom;
            step(0, 1, 1, w[k]);
            if (bus0.clk_out && !prev_clk) cap.push_back(bus0.ReadDataOut);
            prev_clk = bus0.clk_out;
            if (k == 8) begin
                chk("burst_level_at_edge8", int'(bus0.level), 8);
                chk("burst_ovf_at_edge8", int'(bus0.overflow), 0);
            end
            if (k == 9) begin
                chk("burst_level_at_edge9", int'(bus0.level), 8);
                chk("burst_ovf_at_edge9", int'(bus0.overflow), 1);
            end
        end
        n = 0; fell = 1'b0;
        while (n < 400 && !fell) begin
            step(0, 0, 0, 0);
            n++;
            if (bus0.clk_out && !prev_clk) cap.push_back(bus0.ReadDataOut);
            prev_clk = bus0.clk_out;
            if (!bus0.busy) fell = 1'b1;
        end
        chk("burst_busy_fell", int'(fell), 1);
        chk("burst_idle_edge", 9 + n, 145);
        chk("burst_ovf_sticky", int'(bus0.overflow), 1);
        chk("burst_chunk_count", cap.size(), 36);
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 4; c++) begin
                wa = w[k];
                if (k * 4 + c < cap.size())
                    chk($sformatf("burst_w%0d_c%0d", k, c), int'(cap[k*4+c]), int'(wa[c*8 +: 8]));
                else
                    chk($sformatf("burst_w%0d_c%0d_missing", k, c), 0, 1);
            end
        end

        // Full FIFO with a push landing on the pop edge: accepted, no overflow.
        step(1, 0, 0, 0);
        for (int k = 0; k < 9; k++) step(0, 1, 1, $urandom);
        chk("fullpop_level_full", int'(bus0.level), 8);
        for (int k = 9; k < 17; k++) step(0, 0, 0, 0);
        chk("fullpop_level_before", int'(bus0.level), 8);
        step(0, 1, 1, 32'hCAFEF00D);
        chk("fullpop_level_after", int'(bus0.level), 8);
        chk("fullpop_overflow", int'(bus0.overflow), 0);

        // Reset in the middle of chunk 2 with three words queued, push ignored on the reset edge.
        step(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            w[k] = $urandom;
            step(0, 1, 1, w[k]);
        end
        for (int k = 4; k <= 10; k++) step(0, 0, 0, 0);
        wa = w[0];
        chk("midrst_chunk2", int'(bus0.ReadDataOut), int'(wa[23:16]));
        chk("midrst_level_before", int'(bus0.level), 3);
        step(1, 1, 1, 32'h5A5A5A5A);
        chk("midrst_clk_out", int'(bus0.clk_out), 0);
        chk("midrst_dout", int'(bus0.ReadDataOut), 0);
        chk("midrst_level", int'(bus0.level), 0);
        chk("midrst_busy", int'(bus0.busy), 0);
        chk("midrst_overflow", int'(bus0.overflow), 0);
        wa = 32'h01234567;
        step(0, 1, 1, wa);
        step(0, 0, 0, 0);
        chk("postrst_first_chunk", int'(bus0.ReadDataOut), int'(wa[7:0]));
        chk("postrst_level", int'(bus0.level), 0);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0);

        // Randomised traffic with varying push density and rare resets.
        p = 50;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) p = $urandom_range(5, 100);
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 99) < p),
                 ($urandom_range(0, 99) < p),
                 $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/com_stream_bridge.md
COM_STREAM_BRIDGE -- requirements
Module: com_stream_bridge

Interface
REQ-001 Parameter DATA_W, default 32, width of captured data words.
REQ-002 Parameter OUT_W, default 8, width of each output chunk; DATA_W SHALL be an integer multiple of OUT_W.
REQ-003 Parameter DEPTH, default 8, capture FIFO depth in words; power of two, >= 2.
REQ-004 Parameter DIV, default 2, cycles per clk_out half-period; >= 1.
REQ-005 Parameter MSB_FIRST, default 0; 0 sends the least-significant chunk first, 1 sends the most-significant chunk first.
REQ-006 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 MemtoReg  input  1  CPU memory-stage load indicator.
REQ-009 COM  input  1  CPU communication flag; qualifies capture.
REQ-010 ReadData  input  DATA_W  data-memory read word.
REQ-011 clk_out  output  1  generated strobe for the external receiver; a chunk SHALL be sampled on its rising edge.
REQ-012 ReadDataOut  output  OUT_W  current chunk.
REQ-013 level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-014 busy  output  1  high while the FIFO is non-empty or a word is being sent.
REQ-015 overflow  output  1  sticky flag for a dropped word.

Function
REQ-016 Push: at every rising edge where COM=1 and MemtoReg=1, ReadData SHALL be written to the FIFO tail, provided the FIFO is not full after any same-edge pop.
REQ-017 Push while full with no same-edge pop: the word SHALL be dropped, level SHALL be unchanged, and overflow SHALL be set to 1; overflow SHALL clear only on reset.
REQ-018 Push on the same edge as a pop of a full FIFO: the push SHALL be accepted and level SHALL remain DEPTH.
REQ-019 No bypass: a pop SHALL occur only when level != 0 before the edge, so the minimum latency from push edge to the first chunk on ReadDataOut is 1 cycle.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; level SHALL equal pushes minus pops and never exceed DEPTH.
REQ-021 FSM states: IDLE, LOW, HIGH; a cycle counter SHALL count 0..DIV-1 and a chunk index SHALL count 0..DATA_W/OUT_W-1.
REQ-022 IDLE with level != 0: on the next edge, pop the head word into the shift register, drive chunk 0 on ReadDataOut, set clk_out=0, and go to LOW.
REQ-023 LOW: clk_out SHALL be 0 for DIV cycles, then go to HIGH.
REQ-024 HIGH: clk_out SHALL be 1 for DIV cycles; ReadDataOut SHALL be stable for all of LOW and HIGH.
REQ-025 End of HIGH with chunks remaining: drive the next chunk, set clk_out=0, and go to LOW.
REQ-026 End of HIGH on the last chunk with level != 0: pop the next word and drive its chunk 0 on the same edge, with no idle gap, then go to LOW.
REQ-027 End of HIGH on the last chunk with level = 0: go to IDLE with clk_out=0; ReadDataOut SHALL hold the last chunk.
REQ-028 Each word SHALL occupy exactly (DATA_W/OUT_W)*2*DIV cycles of output.
REQ-029 Chunk k SHALL be ReadData[k*OUT_W +: OUT_W] when MSB_FIRST=0, and the mirrored chunk order when MSB_FIRST=1.
REQ-030 busy SHALL equal (state != IDLE) OR (level != 0).
REQ-031 COM or MemtoReg changes during a transmission SHALL NOT affect the word being sent.

Reset
REQ-032 With reset=1 at an edge: clk_out=0, ReadDataOut=0, level=0, overflow=0, busy=0, state=IDLE, FIFO pointers and counters=0.
REQ-033 Reset mid-transmission SHALL abort the word and discard FIFO contents; a push asserted on a reset edge SHALL be ignored.

Verification
REQ-034 Defaults; push 0xAABBCCDD at edge 0 -> ReadDataOut shows DD, CC, BB, AA, each for 4 cycles with clk_out pattern 0,0,1,1; busy falls after 16 cycles; FIFO holds no stale data.
REQ-035 MSB_FIRST=1, same push -> chunk order AA, BB, CC, DD.
REQ-036 Defaults; 10 back-to-back pushes w0..w9 at edges 0..9 -> level reaches 8 at edge 8; w9 dropped; overflow=1 from edge 9; w0..w8 sent contiguously with no gap between words.
REQ-037 COM=0 with MemtoReg=1, or COM=1 with MemtoReg=0, for 5 cycles -> level stays 0 and clk_out stays 0.
REQ-038 Reset asserted during chunk 2 of a word with 3 words queued -> all outputs equal the REQ-032 values on the next edge; a later push transmits normally.
REQ-039 Full FIFO with a simultaneous push and pop -> level stays 8 and overflow stays 0.
